rf_wrctl: RTL and testbench

- Write-side glue for the PQR5 Register File (RF). It merges writeback results from the EXU (ALU/branch-link) and the LSU (load responses) onto the single RF write port.
- A small LSU result buffer absorbs port collisions. Buffered loads that a younger EXU write overwrites to the same rdt are killed (WAW). A starvation guard holds off the EXU so that loads cannot wait forever.
- The registered RF write strobe and rdt also serve as the writeback enable/address consumed by the RF read control and operand forwarding.

---
 rtl/rf_wrctl.sv | 148 ++++++++++++++
 tb/tb_rf_wrctl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rf_wrctl.sv
// Register-file write-port arbiter: merges EXU and LSU writeback results onto one
// registered RF write port, with a small load buffer, WAW kill and starvation guard.
module rf_wrctl #(
  parameter int XLEN          = 32,
  parameter int LSU_BUF_DEPTH = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_exu_valid,
  input  logic [4:0]                       i_exu_rdt,
  input  logic [XLEN-1:0]                  i_exu_data,
  output logic                             o_exu_ready,
  input  logic                             i_lsu_valid,
  input  logic [4:0]                       i_lsu_rdt,
  input  logic [XLEN-1:0]                  i_lsu_data,
  output logic                             o_lsu_ready,
  output logic                             o_rf_wren,
  output logic [4:0]                       o_rf_rdt_addr,
  output logic [XLEN-1:0]                  o_rf_wdata,
  output logic [31:0]                      o_pend_mask,
  output logic [$clog2(LSU_BUF_DEPTH):0]   o_buf_cnt
);

  localparam int PW = $clog2(LSU_BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]               buf_rdt_q  [LSU_BUF_DEPTH];
  logic [XLEN-1:0]          buf_data_q [LSU_BUF_DEPTH];
  logic [LSU_BUF_DEPTH-1:0] live_q, live_d, kill_hit;
  logic [PW-1:0]            head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [AW-1:0]            age_q, age_d;
  logic                     wren_q, wren_d;
  logic [4:0]               addr_q, addr_d;
  logic [XLEN-1:0]          wdata_q, wdata_d;

  logic head_live, buf_empty, force_drain;
  logic exu_acc, exu_wr, lsu_acc, lsu_wr;
  logic pop, enq, bypass;

  assign buf_empty   = (cnt_q == '0);
  assign head_live   = live_q[head_q];
  assign force_drain = (age_q >= AW'(STARVE_LIMIT));
  assign o_exu_ready = ~force_drain;
  assign o_lsu_ready = (cnt_q < CW'(LSU_BUF_DEPTH));

  assign exu_acc = i_exu_valid & o_exu_ready;
  assign exu_wr  = exu_acc & (i_exu_rdt != 5'd0);
  assign lsu_acc = i_lsu_valid & o_lsu_ready;
  // A same-cycle EXU write to the same register is younger, so the load is dropped.
  assign lsu_wr  = lsu_acc & (i_lsu_rdt != 5'd0) & ~(exu_wr & (i_lsu_rdt == i_exu_rdt));

  always_comb begin
    pop     = 1'b0;
    bypass  = 1'b0;
    wren_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (force_drain && head_live) begin
      wren_d  = 1'b1;
      addr_d  = buf_rdt_q[head_q];
      wdata_d = buf_data_q[head_q];
      pop     = 1'b1;
    end else if (exu_wr) begin
      wren_d  = 1'b1;
      addr_d  = i_exu_rdt;
      wdata_d = i_exu_data;
      pop     = ~buf_empty & ~head_live;
    end else if (head_live) begin
      wren_d  = 1'b1;
      addr_d  = buf_rdt_q[head_q];
      wdata_d = buf_data_q[head_q];
      pop     = 1'b1;
    end else begin
      // Dead head leaves without a write; an empty buffer lets a load bypass.
      pop = ~buf_empty;
      if (buf_empty && lsu_wr) begin
        bypass  = 1'b1;
        wren_d  = 1'b1;
        addr_d  = i_lsu_rdt;
        wdata_d = i_lsu_data;
      end
    end
  end

  assign enq = lsu_wr & ~bypass;

  for (genvar gi = 0; gi < LSU_BUF_DEPTH; gi++) begin : g_live
    assign kill_hit[gi] = exu_wr & (buf_rdt_q[gi] == i_exu_rdt);
    assign live_d[gi]   = (live_q[gi] & ~kill_hit[gi] & ~(pop && head_q == PW'(gi)))
                        | (enq && tail_q == PW'(gi));
  end

  always_comb begin
    head_d = pop ? head_q + PW'(1) : head_q;
    tail_d = enq ? tail_q + PW'(1) : tail_q;
    cnt_d  = cnt_q + CW'(enq) - CW'(pop);
    age_d  = age_q;
    if (pop || buf_empty)
      age_d = '0;
    else if (head_live && age_q < AW'(STARVE_LIMIT))
      age_d = age_q + AW'(1);
  end

  always_comb begin
    o_pend_mask = '0;
    for (int i = 0; i < LSU_BUF_DEPTH; i++)
      if (live_q[i]) o_pend_mask[buf_rdt_q[i]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      age_q   <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      live_q  <= live_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      age_q   <= age_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Payload storage needs no reset; the live bits qualify it.
  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      buf_rdt_q[tail_q]  <= i_lsu_rdt;
      buf_data_q[tail_q] <= i_lsu_data;
    end
  end

  assign o_rf_wren     = wren_q;
  assign o_rf_rdt_addr = addr_q;
  assign o_rf_wdata    = wdata_q;
  assign o_buf_cnt     = cnt_q;

endmodule

// File: tb/tb_rf_wrctl.sv
// Directed table-driven bench for rf_wrctl: each row is one cycle of inputs and the
// outputs expected just after that cycle's clock edge.
module tb_rf_wrctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_exu_valid;
  logic [4:0]  i_exu_rdt;
  logic [31:0] i_exu_data;
  logic        o_exu_ready;
  logic        i_lsu_valid;
  logic [4:0]  i_lsu_rdt;
  logic [31:0] i_lsu_data;
  logic        o_lsu_ready;
  logic        o_rf_wren;
  logic [4:0]  o_rf_rdt_addr;
  logic [31:0] o_rf_wdata;
  logic [31:0] o_pend_mask;
  logic [1:0]  o_buf_cnt;

  rf_wrctl #(.XLEN(32), .LSU_BUF_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_exu_valid(i_exu_valid), .i_exu_rdt(i_exu_rdt), .i_exu_data(i_exu_data),
    .o_exu_ready(o_exu_ready),
    .i_lsu_valid(i_lsu_valid), .i_lsu_rdt(i_lsu_rdt), .i_lsu_data(i_lsu_data),
    .o_lsu_ready(o_lsu_ready),
    .o_rf_wren(o_rf_wren), .o_rf_rdt_addr(o_rf_rdt_addr), .o_rf_wdata(o_rf_wdata),
    .o_pend_mask(o_pend_mask), .o_buf_cnt(o_buf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        ev;
    logic [4:0]  er;
    logic [31:0] ed;
    logic        lv;
    logic [4:0]  lr;
    logic [31:0] ld;
    logic        x_wren;
    logic [4:0]  x_addr;
    logic [31:0] x_data;
    logic [31:0] x_pend;
    logic [1:0]  x_cnt;
    logic        x_eready;
    logic        x_lready;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic v(input string name, input logic r,
                   input logic ev, input logic [4:0] er, input logic [31:0] ed,
                   input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                   input logic xw, input logic [4:0] xa, input logic [31:0] xd,
                   input logic [31:0] xp, input logic [1:0] xc,
                   input logic xer, input logic xlr);
    vec_t t;
    t.name = name; t.rst = r; t.ev = ev; t.er = er; t.ed = ed;
    t.lv = lv; t.lr = lr; t.ld = ld;
    t.x_wren = xw; t.x_addr = xa; t.x_data = xd; t.x_pend = xp; t.x_cnt = xc;
    t.x_eready = xer; t.x_lready = xlr;
    vecs.push_back(t);
  endtask

  task automatic check(input vec_t t);
    n_checks++;
    if (o_rf_wren === t.x_wren && o_rf_rdt_addr === t.x_addr && o_rf_wdata === t.x_data &&
        o_pend_mask === t.x_pend && o_buf_cnt === t.x_cnt &&
        o_exu_ready === t.x_eready && o_lsu_ready === t.x_lready) begin
      n_pass++;
      $display("ok   %-12s wren=%0d addr=%0d wdata=%h pend=%h cnt=%0d erdy=%0d lrdy=%0d",
               t.name, o_rf_wren, o_rf_rdt_addr, o_rf_wdata, o_pend_mask, o_buf_cnt,
               o_exu_ready, o_lsu_ready);
    end else begin
      $display("FAIL %-12s got wren=%0d addr=%0d wdata=%h pend=%h cnt=%0d erdy=%0d lrdy=%0d | want wren=%0d addr=%0d wdata=%h pend=%h cnt=%0d erdy=%0d lrdy=%0d",
               t.name, o_rf_wren, o_rf_rdt_addr, o_rf_wdata, o_pend_mask, o_buf_cnt,
               o_exu_ready, o_lsu_ready, t.x_wren, t.x_addr, t.x_data, t.x_pend,
               t.x_cnt, t.x_eready, t.x_lready);
    end
  endtask

  initial begin
    //   name          rst ev er  ed            lv lr  ld           wren addr wdata        pend        cnt erdy lrdy
    v("reset",         1, 0, 0,  32'h0,        0, 0,  32'h0,       0, 0,  32'h0,        32'h0,      0, 1, 1);
    v("exu_x5",        0, 1, 5,  32'hDEADBEEF, 0, 0,  32'h0,       1, 5,  32'hDEADBEEF, 32'h0,      0, 1, 1);
    v("exu_x0",        0, 1, 0,  32'h1234,     0, 0,  32'h0,       0, 5,  32'hDEADBEEF, 32'h0,      0, 1, 1);
    v("coll_exu",      0, 1, 3,  32'h11,       1, 4,  32'h22,      1, 3,  32'h11,       32'h10,     1, 1, 1);
    v("coll_lsu",      0, 0, 0,  32'h0,        0, 0,  32'h0,       1, 4,  32'h22,       32'h0,      0, 1, 1);
    v("idle",          0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 4,  32'h22,       32'h0,      0, 1, 1);
    v("bypass_x9",     0, 0, 0,  32'h0,        1, 9,  32'h99,      1, 9,  32'h99,       32'h0,      0, 1, 1);
    v("waw_buf",       0, 1, 1,  32'h1,        1, 7,  32'hA,       1, 1,  32'h1,        32'h80,     1, 1, 1);
    v("waw_kill",      0, 1, 7,  32'hB,        0, 0,  32'h0,       1, 7,  32'hB,        32'h0,      1, 1, 1);
    v("waw_deadpop",   0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 7,  32'hB,        32'h0,      0, 1, 1);
    v("drop_same",     0, 1, 6,  32'h66,       1, 6,  32'h77,      1, 6,  32'h66,       32'h0,      0, 1, 1);
    v("drop_after",    0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 6,  32'h66,       32'h0,      0, 1, 1);
    v("stv_enq",       0, 1, 2,  32'h20,       1, 8,  32'h80,      1, 2,  32'h20,       32'h100,    1, 1, 1);
    v("stv_w1",        0, 1, 2,  32'h21,       0, 0,  32'h0,       1, 2,  32'h21,       32'h100,    1, 1, 1);
    v("stv_w2",        0, 1, 2,  32'h22,       0, 0,  32'h0,       1, 2,  32'h22,       32'h100,    1, 1, 1);
    v("stv_w3",        0, 1, 2,  32'h23,       0, 0,  32'h0,       1, 2,  32'h23,       32'h100,    1, 1, 1);
    v("stv_w4",        0, 1, 2,  32'h24,       0, 0,  32'h0,       1, 2,  32'h24,       32'h100,    1, 0, 1);
    v("stv_drain",     0, 1, 2,  32'h25,       0, 0,  32'h0,       1, 8,  32'h80,       32'h0,      0, 1, 1);
    v("stv_retry",     0, 1, 2,  32'h25,       0, 0,  32'h0,       1, 2,  32'h25,       32'h0,      0, 1, 1);
    v("bp_fill1",      0, 1, 10, 32'hA0,       1, 11, 32'hB0,      1, 10, 32'hA0,       32'h800,    1, 1, 1);
    v("bp_fill2",      0, 1, 10, 32'hA1,       1, 12, 32'hC0,      1, 10, 32'hA1,       32'h1800,   2, 1, 0);
    v("bp_held1",      0, 1, 10, 32'hA2,       1, 13, 32'hD0,      1, 10, 32'hA2,       32'h1800,   2, 1, 0);
    v("bp_held2",      0, 1, 10, 32'hA3,       1, 13, 32'hD0,      1, 10, 32'hA3,       32'h1800,   2, 1, 0);
    v("bp_held3",      0, 1, 10, 32'hA4,       1, 13, 32'hD0,      1, 10, 32'hA4,       32'h1800,   2, 0, 0);
    v("bp_drain",      0, 1, 10, 32'hA5,       1, 13, 32'hD0,      1, 11, 32'hB0,       32'h1000,   1, 1, 1);
    v("bp_accept3",    0, 1, 10, 32'hA5,       1, 13, 32'hD0,      1, 10, 32'hA5,       32'h3000,   2, 1, 0);
    v("rst_mid",       1, 1, 14, 32'hE0,       0, 0,  32'h0,       0, 0,  32'h0,        32'h0,      0, 1, 1);
    v("post_rst1",     0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 0,  32'h0,        32'h0,      0, 1, 1);
    v("post_rst2",     0, 0, 0,  32'h0,        0, 0,  32'h0,       0, 0,  32'h0,        32'h0,      0, 1, 1);
    v("exu_x31",       0, 1, 31, 32'hFFFFFFFF, 0, 0,  32'h0,       1, 31, 32'hFFFFFFFF, 32'h0,      0, 1, 1);

    rst = 1'b1; i_exu_valid = 1'b0; i_exu_rdt = '0; i_exu_data = '0;
    i_lsu_valid = 1'b0; i_lsu_rdt = '0; i_lsu_data = '0;
    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst         = vecs[i].rst;
      i_exu_valid = vecs[i].ev;
      i_exu_rdt   = vecs[i].er;
      i_exu_data  = vecs[i].ed;
      i_lsu_valid = vecs[i].lv;
      i_lsu_rdt   = vecs[i].lr;
      i_lsu_data  = vecs[i].ld;
      @(posedge clk);
      #1;
      check(vecs[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
